trapresolve: RTL and testbench

Resolves the trap for the instruction in the Memory stage: synchronizes external interrupt lines, registers pending interrupts, applies global enables, priority, and M/HS/VS delegation, and runs the WFI stall/timeout counter. It produces TrapM, DelegateM, the one-hot trap target and the cause. Its outputs feed the privilege-mode tracker and the CSR trap-entry logic directly.

---
 rtl/trapresolve_pkg.sv | 51 +++++
 rtl/trapresolve_if.sv | 49 ++++
 rtl/trapresolve_intpriority.sv | 22 ++
 rtl/trapresolve.sv | 151 +++++++++++++++
 tb/tb_trapresolve.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trapresolve_pkg.sv
// Shared constants for trapresolve: core configuration, interrupt bit indices,
// cause codes, and the fixed interrupt priority order.
package trapresolve_pkg;

  typedef struct packed {
    logic       U_SUPPORTED;
    logic       S_SUPPORTED;
    logic       H_SUPPORTED;
    logic [1:0] M_MODE;
    logic [1:0] S_MODE;
    logic [1:0] U_MODE;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{
    U_SUPPORTED: 1'b1,
    S_SUPPORTED: 1'b1,
    H_SUPPORTED: 1'b1,
    M_MODE:      2'b11,
    S_MODE:      2'b01,
    U_MODE:      2'b00
  };

  localparam int unsigned NUM_INT = 12;

  localparam int unsigned IRQ_SSI  = 1;
  localparam int unsigned IRQ_VSSI = 2;
  localparam int unsigned IRQ_MSI  = 3;
  localparam int unsigned IRQ_STI  = 5;
  localparam int unsigned IRQ_VSTI = 6;
  localparam int unsigned IRQ_MTI  = 7;
  localparam int unsigned IRQ_SEI  = 9;
  localparam int unsigned IRQ_VSEI = 10;
  localparam int unsigned IRQ_MEI  = 11;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;

  // Highest priority first.
  localparam int unsigned INT_PRIO_N = 9;
  localparam int unsigned INT_PRIO [INT_PRIO_N] = '{
    IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI,
    IRQ_VSEI, IRQ_VSSI, IRQ_VSTI
  };

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_M,
    TGT_HS,
    TGT_VS
  } trap_tgt_e;

endpackage

// File: rtl/trapresolve_if.sv
// Signal bundle between the Memory-stage control/CSR side and trapresolve.
// master drives the pipeline/CSR state; slave is the trap resolver.
interface trapresolve_if;
  logic        StallW;
  logic        InstrValidM;
  logic        ExcValidM;
  logic [4:0]  ExcCauseM;
  logic        wfiM;
  logic        MExtIntRaw;
  logic        SExtIntRaw;
  logic [11:0] MIP_REGW;
  logic [11:0] MIE_REGW;
  logic [11:0] MIDELEG_REGW;
  logic [11:0] HIDELEG_REGW;
  logic [15:0] MEDELEG_REGW;
  logic [15:0] HEDELEG_REGW;
  logic        STATUS_MIE;
  logic        STATUS_SIE;
  logic        VSSTATUS_SIE;
  logic        STATUS_TW;
  logic [1:0]  PrivilegeModeW;
  logic        VirtModeW;

  logic        TrapM;
  logic        InterruptM;
  logic [4:0]  CauseM;
  logic        DelegateM;
  logic        TrapToM;
  logic        TrapToHS;
  logic        TrapToVS;
  logic        WFIStallM;
  logic [11:0] PendingIntsM;

  modport master (
    output StallW, InstrValidM, ExcValidM, ExcCauseM, wfiM, MExtIntRaw, SExtIntRaw,
           MIP_REGW, MIE_REGW, MIDELEG_REGW, HIDELEG_REGW, MEDELEG_REGW, HEDELEG_REGW,
           STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW, PrivilegeModeW, VirtModeW,
    input  TrapM, InterruptM, CauseM, DelegateM, TrapToM, TrapToHS, TrapToVS,
           WFIStallM, PendingIntsM
  );

  modport slave (
    input  StallW, InstrValidM, ExcValidM, ExcCauseM, wfiM, MExtIntRaw, SExtIntRaw,
           MIP_REGW, MIE_REGW, MIDELEG_REGW, HIDELEG_REGW, MEDELEG_REGW, HEDELEG_REGW,
           STATUS_MIE, STATUS_SIE, VSSTATUS_SIE, STATUS_TW, PrivilegeModeW, VirtModeW,
    output TrapM, InterruptM, CauseM, DelegateM, TrapToM, TrapToHS, TrapToVS,
           WFIStallM, PendingIntsM
  );
endinterface

// File: rtl/trapresolve_intpriority.sv
// Combinational fixed-priority encoder over the eligible interrupt vector;
// bits not in the priority table are never selected.
module intpriority
  import trapresolve_pkg::*;
(
  input  logic [NUM_INT-1:0] eligible_i,
  output logic               valid_o,
  output logic [4:0]         cause_o
);

  always_comb begin
    valid_o = 1'b0;
    cause_o = '0;
    for (int unsigned k = 0; k < INT_PRIO_N; k++) begin
      if (!valid_o && eligible_i[INT_PRIO[k]]) begin
        valid_o = 1'b1;
        cause_o = 5'(INT_PRIO[k]);
      end
    end
  end

endmodule

// File: rtl/trapresolve.sv
// Memory-stage trap resolution: interrupt sync/pending, eligibility, priority,
// delegation and WFI stall. WFI timeout trap enabled by TRAP_WFI_TIMEOUT_EN.
module trapresolve
  import trapresolve_pkg::*;
#(
  parameter cvw_t        P           = CVW_DEFAULT,
  parameter int unsigned WFI_TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset_n,
  trapresolve_if.slave tr
);

  logic              mext_s1_q, mext_s2_q, sext_s1_q, sext_s2_q;
  logic [NUM_INT-1:0] mip_merged, pend_d, pend_q;
  logic [NUM_INT-1:0] mideleg, hideleg, en_mask, eligible;
  logic [15:0]       medeleg, hedeleg;
  logic              priv_m, priv_s, priv_u;
  logic              int_valid, int_taken;
  logic [4:0]        int_cause;
  logic              wfi_timeout, wfi_stall;
  logic              trap, intr, exc_hs, exc_vs;
  logic [4:0]        cause, exc_cause;
  trap_tgt_e         tgt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mext_s1_q <= 1'b0;
      mext_s2_q <= 1'b0;
      sext_s1_q <= 1'b0;
      sext_s2_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      mext_s1_q <= tr.MExtIntRaw;
      mext_s2_q <= mext_s1_q;
      sext_s1_q <= tr.SExtIntRaw;
      sext_s2_q <= sext_s1_q;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    mip_merged          = tr.MIP_REGW;
    mip_merged[IRQ_MEI] = tr.MIP_REGW[IRQ_MEI] | mext_s2_q;
    mip_merged[IRQ_SEI] = tr.MIP_REGW[IRQ_SEI] | sext_s2_q;
  end

  assign pend_d = mip_merged & tr.MIE_REGW;

  assign mideleg = P.S_SUPPORTED ? tr.MIDELEG_REGW : '0;
  assign medeleg = P.S_SUPPORTED ? tr.MEDELEG_REGW : '0;
  assign hideleg = P.H_SUPPORTED ? tr.HIDELEG_REGW : '0;
  assign hedeleg = P.H_SUPPORTED ? tr.HEDELEG_REGW : '0;

  assign priv_m = (tr.PrivilegeModeW == P.M_MODE);
  assign priv_s = (tr.PrivilegeModeW == P.S_MODE);
  assign priv_u = (tr.PrivilegeModeW == P.U_MODE);

  // Per-bit global enable, depending on where the bit is delegated to.
  always_comb begin
    en_mask = '0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (!mideleg[i])
        en_mask[i] = !priv_m || tr.STATUS_MIE;
      else if (!hideleg[i])
        en_mask[i] = !priv_m && (priv_u || tr.VirtModeW ||
                                 (priv_s && !tr.VirtModeW && tr.STATUS_SIE));
      else
        en_mask[i] = tr.VirtModeW && (priv_u || tr.VSSTATUS_SIE);
    end
  end

  assign eligible = pend_q & en_mask;

  intpriority u_intpriority (
    .eligible_i (eligible),
    .valid_o    (int_valid),
    .cause_o    (int_cause)
  );

  assign int_taken = int_valid && tr.InstrValidM && !tr.StallW;

  // The WFI timeout reuses the exception delegation path with the illegal-instruction cause.
  always_comb begin
    trap      = 1'b0;
    intr      = 1'b0;
    cause     = '0;
    tgt       = TGT_NONE;
    exc_cause = tr.ExcValidM ? tr.ExcCauseM : CAUSE_ILLEGAL_INSTR;
    exc_hs    = !priv_m && !exc_cause[4] && medeleg[exc_cause[3:0]];
    exc_vs    = exc_hs && tr.VirtModeW && hedeleg[exc_cause[3:0]];
    if (int_taken) begin
      trap  = 1'b1;
      intr  = 1'b1;
      cause = int_cause;
      if (!mideleg[int_cause[3:0]])
        tgt = TGT_M;
      else if (hideleg[int_cause[3:0]])
        tgt = TGT_VS;
      else
        tgt = TGT_HS;
    end else if (tr.ExcValidM || wfi_timeout) begin
      trap  = 1'b1;
      cause = exc_cause;
      tgt   = exc_vs ? TGT_VS : (exc_hs ? TGT_HS : TGT_M);
    end
    if (trap && !P.U_SUPPORTED)
      tgt = TGT_M;
  end

  assign wfi_stall = tr.wfiM && !(|pend_d) && !wfi_timeout;

`ifdef TRAP_WFI_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(WFI_TIMEOUT);

  logic [7:0] wfi_cnt_d, wfi_cnt_q;

  assign wfi_timeout = tr.wfiM && tr.STATUS_TW && !priv_m && (wfi_cnt_q == TimeoutCnt);

  always_comb begin
    wfi_cnt_d = wfi_cnt_q;
    if (!tr.wfiM || trap)
      wfi_cnt_d = '0;
    else if (wfi_stall && (wfi_cnt_q != TimeoutCnt))
      wfi_cnt_d = wfi_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wfi_cnt_q <= '0;
    else          wfi_cnt_q <= wfi_cnt_d;
  end
`else
  localparam int unsigned unused_timeout = WFI_TIMEOUT;
  logic unused_tw;

  assign unused_tw   = tr.STATUS_TW;
  assign wfi_timeout = 1'b0;
`endif

  // Outputs are forced low while reset is asserted, including mid-WFI.
  assign tr.TrapM        = reset_n && trap;
  assign tr.InterruptM   = reset_n && intr;
  assign tr.CauseM       = reset_n ? cause : '0;
  assign tr.TrapToM      = reset_n && (tgt == TGT_M);
  assign tr.TrapToHS     = reset_n && (tgt == TGT_HS);
  assign tr.TrapToVS     = reset_n && (tgt == TGT_VS);
  assign tr.DelegateM    = reset_n && ((tgt == TGT_HS) || (tgt == TGT_VS));
  assign tr.WFIStallM    = reset_n && wfi_stall;
  assign tr.PendingIntsM = pend_q;

endmodule

// File: tb/tb_trapresolve.sv
// Directed self-checking bench for trapresolve; timeout cases follow TRAP_WFI_TIMEOUT_EN.
module tb_trapresolve;
  import trapresolve_pkg::*;

  logic        clk;
  logic        reset_n;
  int unsigned n_checks;
  int unsigned n_fail;

  trapresolve_if bus ();

`ifdef TRAP_WFI_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  trapresolve #(.P(CVW_DEFAULT), .WFI_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tr      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // {TrapM, InterruptM, CauseM, DelegateM, TrapToM, TrapToHS, TrapToVS}
  function automatic logic [10:0] trapv();
    return {bus.TrapM, bus.InterruptM, bus.CauseM, bus.DelegateM,
            bus.TrapToM, bus.TrapToHS, bus.TrapToVS};
  endfunction

  function automatic logic [10:0] tv(input logic t, input logic i, input logic [4:0] c,
                                     input logic d, input logic m, input logic hs,
                                     input logic vs);
    return {t, i, c, d, m, hs, vs};
  endfunction

  function automatic logic [11:0] wv();
    return {bus.WFIStallM, trapv()};
  endfunction

  task automatic clear_inputs();
    bus.StallW         = 1'b0;
    bus.InstrValidM    = 1'b0;
    bus.ExcValidM      = 1'b0;
    bus.ExcCauseM      = '0;
    bus.wfiM           = 1'b0;
    bus.MExtIntRaw     = 1'b0;
    bus.SExtIntRaw     = 1'b0;
    bus.MIP_REGW       = '0;
    bus.MIE_REGW       = '0;
    bus.MIDELEG_REGW   = '0;
    bus.HIDELEG_REGW   = '0;
    bus.MEDELEG_REGW   = '0;
    bus.HEDELEG_REGW   = '0;
    bus.STATUS_MIE     = 1'b0;
    bus.STATUS_SIE     = 1'b0;
    bus.VSSTATUS_SIE   = 1'b0;
    bus.STATUS_TW      = 1'b0;
    bus.PrivilegeModeW = 2'b11;
    bus.VirtModeW      = 1'b0;
  endtask

  // Stall with TW=1 at U: TMO stall cycles then the illegal-instruction trap.
  task automatic wfi_seq(input string pre);
`ifdef TRAP_WFI_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_stall%0d", pre, k), wv(), {1'b1, 11'd0});
      cyc();
      smp();
    end
    check({pre, "_timeout"}, wv(), {1'b0, tv(1, 0, 5'd2, 0, 1, 0, 0)});
`else
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_stall%0d", pre, k), wv(), {1'b1, 11'd0});
      cyc();
      smp();
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clear_inputs();

    // Reset with MEI pending
    bus.PrivilegeModeW = 2'b00;
    bus.MIP_REGW       = 12'h800;
    bus.MIE_REGW       = 12'h800;
    bus.InstrValidM    = 1'b1;
    repeat (3) @(posedge clk);
    smp();
    check("rst_trap", trapv(), '0);
    check("rst_pend", bus.PendingIntsM, '0);
    check("rst_wfi", bus.WFIStallM, '0);
    cyc();
    reset_n = 1'b1;
    smp();
    check("rel_notrap", trapv(), '0);
    cyc();
    smp();
    check("rel_mei", trapv(), tv(1, 1, 5'd11, 0, 1, 0, 0));
    check("rel_pend", bus.PendingIntsM, 12'h800);

    // External interrupt latency
    bus.MIP_REGW = '0;
    cyc();
    bus.MExtIntRaw = 1'b1;
    smp();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ext_lat%0d", k), trapv(), '0);
      cyc();
      smp();
    end
    check("ext_lat3", trapv(), tv(1, 1, 5'd11, 0, 1, 0, 0));
    bus.MExtIntRaw = 1'b0;
    repeat (4) cyc();

    // Delegation to HS and priority over it
    bus.MIE_REGW     = 12'h020;
    bus.MIP_REGW     = 12'h020;
    bus.MIDELEG_REGW = 12'h020;
    cyc();
    smp();
    check("deleg_sti", trapv(), tv(1, 1, 5'd5, 1, 0, 1, 0));
    bus.MIP_REGW = 12'h028;
    bus.MIE_REGW = 12'h028;
    cyc();
    smp();
    check("deleg_msi_prio", trapv(), tv(1, 1, 5'd3, 0, 1, 0, 0));
    bus.StallW = 1'b1;
    #1;
    check("stallw_block", trapv(), '0);
    bus.StallW      = 1'b0;
    bus.InstrValidM = 1'b0;
    #1;
    check("novalid_block", trapv(), '0);
    bus.InstrValidM = 1'b1;

    // M-mode global enable; delegated interrupts never taken in M
    bus.PrivilegeModeW = 2'b11;
    bus.STATUS_MIE     = 1'b0;
    #1;
    check("m_mie0", trapv(), '0);
    bus.STATUS_MIE = 1'b1;
    #1;
    check("m_mie1", trapv(), tv(1, 1, 5'd3, 0, 1, 0, 0));
    bus.MIP_REGW = 12'h020;
    bus.MIE_REGW = 12'h020;
    cyc();
    smp();
    check("m_deleg_never", trapv(), '0);

    // VS routing
    bus.MIP_REGW       = 12'h400;
    bus.MIE_REGW       = 12'h400;
    bus.MIDELEG_REGW   = 12'h400;
    bus.HIDELEG_REGW   = 12'h400;
    bus.VirtModeW      = 1'b1;
    bus.PrivilegeModeW = 2'b01;
    bus.STATUS_MIE     = 1'b0;
    bus.VSSTATUS_SIE   = 1'b0;
    cyc();
    smp();
    check("vs_sie0", trapv(), '0);
    bus.VSSTATUS_SIE = 1'b1;
    #1;
    check("vs_sie1", trapv(), tv(1, 1, 5'd10, 1, 0, 0, 1));

    // Exceptions and interrupt-over-exception
    bus.MIP_REGW     = '0;
    bus.MIE_REGW     = '0;
    bus.MIDELEG_REGW = '0;
    bus.HIDELEG_REGW = '0;
    bus.VirtModeW    = 1'b0;
    bus.VSSTATUS_SIE = 1'b0;
    cyc();
    bus.ExcValidM    = 1'b1;
    bus.ExcCauseM    = 5'd13;
    bus.MEDELEG_REGW = 16'h2000;
    smp();
    check("exc_hs", trapv(), tv(1, 0, 5'd13, 1, 0, 1, 0));
    bus.StallW = 1'b1;
    #1;
    check("exc_stallw", trapv(), tv(1, 0, 5'd13, 1, 0, 1, 0));
    bus.StallW         = 1'b0;
    bus.PrivilegeModeW = 2'b11;
    #1;
    check("exc_m", trapv(), tv(1, 0, 5'd13, 0, 1, 0, 0));
    bus.PrivilegeModeW = 2'b01;
    bus.VirtModeW      = 1'b1;
    bus.HEDELEG_REGW   = 16'h2000;
    #1;
    check("exc_vs", trapv(), tv(1, 0, 5'd13, 1, 0, 0, 1));
    bus.VirtModeW    = 1'b0;
    bus.HEDELEG_REGW = '0;
    bus.MIP_REGW     = 12'h080;
    bus.MIE_REGW     = 12'h080;
    cyc();
    smp();
    check("exc_vs_mti", trapv(), tv(1, 1, 5'd7, 0, 1, 0, 0));
    bus.ExcValidM    = 1'b0;
    bus.ExcCauseM    = '0;
    bus.MIP_REGW     = '0;
    bus.MIE_REGW     = '0;
    bus.MEDELEG_REGW = '0;
    cyc();

    // WFI with TW=1 at U
    bus.PrivilegeModeW = 2'b00;
    bus.STATUS_TW      = 1'b1;
    bus.wfiM           = 1'b1;
    smp();
    wfi_seq("wfi");
`ifdef TRAP_WFI_TIMEOUT_EN
    cyc();
    smp();
    check("wfi_restart", wv(), {1'b1, 11'd0});
`endif

    // TW=0: stall persists; wake ignores global enables
    bus.wfiM = 1'b0;
    cyc();
    bus.wfiM      = 1'b1;
    bus.STATUS_TW = 1'b0;
    smp();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("wfi_tw0_%0d", k), wv(), {1'b1, 11'd0});
      cyc();
      smp();
    end
    bus.PrivilegeModeW = 2'b11;
    bus.STATUS_MIE     = 1'b0;
    bus.MIP_REGW       = 12'h080;
    bus.MIE_REGW       = 12'h080;
    #1;
    check("wfi_wake", wv(), '0);
    cyc();
    smp();
    check("wfi_wake_noint", wv(), '0);
    check("wfi_wake_pend", bus.PendingIntsM, 12'h080);

    // Asynchronous reset mid-WFI
    bus.MIP_REGW       = '0;
    bus.MIE_REGW       = '0;
    bus.wfiM           = 1'b0;
    bus.PrivilegeModeW = 2'b00;
    bus.STATUS_TW      = 1'b1;
    cyc();
    bus.wfiM = 1'b1;
    smp();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pre_rst_stall%0d", k), wv(), {1'b1, 11'd0});
      if (k < 2) begin
        cyc();
        smp();
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wfi", wv(), '0);
    cyc();
    reset_n = 1'b1;
    smp();
    wfi_seq("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
